rob_retire_ctl: RTL
===================

# rob_retire_ctl

In-order retirement controller for the reorder buffer. Each cycle it inspects the head slots the reorder buffer exposes and decides how many consecutive completed entries to retire, up to EXT_COUNT. It drives the reorder-buffer consume handshake, the architectural register-file write ports, a single-outstanding store-commit handshake to the data memory, and a pipeline flush on a faulting head entry. It sits between the reorder buffer's retrieve interface and the register file / store port.

## Interface
- EXT_COUNT, 2: head slots inspected per cycle; supported values are 1 and 2.
- EXTCOUNTLOG2, $clog2(EXT_COUNT): width of consume_count; minimum 1.
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- slot_valid[EXT_COUNT]  in  1  head slot i holds a completed result; slot 0 is the oldest entry
- slot_dest_reg[EXT_COUNT]  in  5  destination register of slot i
- slot_dest_valid[EXT_COUNT]  in  1  slot i writes a register
- slot_result[EXT_COUNT]  in  32  result value of slot i
- slot_is_store[EXT_COUNT]  in  1  slot i is a store
- slot_st_addr[EXT_COUNT], slot_st_data[EXT_COUNT]  in  32  store address and store data of slot i
- slot_exc[EXT_COUNT]  in  1  slot i faulted
- slot_pc[EXT_COUNT]  in  32  PC of slot i
- empty  in  1  reorder buffer empty
- consume  out  1  retire entries this cycle
- consume_count  out  EXTCOUNTLOG2  number retired minus 1
- rf_we[EXT_COUNT]  out  1  register-file write enable, port i
- rf_waddr[EXT_COUNT]  out  5  register-file write address, port i
- rf_wdata[EXT_COUNT]  out  32  register-file write data, port i
- st_req  out  1  store-commit request, registered
- st_addr, st_data  out  32  store address and data, registered
- st_ack  in  1  memory accepted the store
- flush  out  1  one-cycle flush pulse, registered
- flush_pc  out  32  PC of the faulting entry, registered
- flush_done  in  1  front end and reorder buffer are cleared
- retired_count  out  32  count of retired instructions

## Operation
- FSM states: RUN, ST_WAIT, FLUSH. Reset state is RUN.
- Reset values: consume=0, consume_count=0, rf_we=0, rf_waddr=0, rf_wdata=0, st_req=0, st_addr=0, st_data=0, flush=0, flush_pc=0, retired_count=0.
- Behaviour in RUN, with head = slot 0:
  - If empty=1 or slot_valid[0]=0: no action.
  - If slot_exc[0]=1: set flush=1 and flush_pc=slot_pc[0] on the next edge, then go to FLUSH. Do not consume. Do not write the register file. Exception takes priority over store.
  - Else if slot_is_store[0]=1: set st_req=1 and latch st_addr/st_data from slot 0 on the next edge, then go to ST_WAIT. Do not consume.
  - Else slot 0 retires: rf_we[0]=slot_dest_valid[0] and (slot_dest_reg[0]!=0).
- Slot 1 (EXT_COUNT=2 only) retires in the same cycle only if all of these hold:
  - slot 0 retires in RUN;
  - slot_valid[1]=1, slot_exc[1]=0 and slot_is_store[1]=0.
  - In that case consume_count=1, otherwise consume_count=0.
  - A faulting or store slot 1 is left at the head for the next cycle.
- Write ports: rf_waddr[i] and rf_wdata[i] follow slot i directly.
- Same-register write by both ports in one cycle: port 1 (younger) wins. The register file's priority honours this; the controller does not suppress port 0.
- ST_WAIT:
  - st_req is held with st_addr/st_data stable until st_ack=1.
  - On the cycle with st_ack=1: consume=1, consume_count=0, next state RUN, st_req clears on the next edge.
  - No other retirement occurs while in ST_WAIT.
- FLUSH:
  - flush is high for exactly one cycle.
  - No consume, no rf_we, no st_req.
  - Leave to RUN on the cycle flush_done=1.
- retired_count increments by the number retired (consume_count+1 when consume=1) and wraps modulo 2^32.
- Asynchronous reset mid-store or mid-flush: all outputs clear immediately and the state goes to RUN. An in-flight store is abandoned; the memory side is reset by the same reset.

## Timing
- consume, consume_count, rf_we, rf_waddr and rf_wdata are combinational from the slot inputs and state. Zero-cycle latency: the ROB pointer advances on the same edge the register file writes.
- st_req, st_addr, st_data, flush and flush_pc are registered: they assert 1 cycle after the head is seen.
- Minimum store retirement latency is 2 cycles (request edge, then ack cycle). Back-to-back stores therefore retire at most one every 2 cycles.
- st_ack is only sampled in ST_WAIT; st_ack outside ST_WAIT is ignored.
- flush_done is only sampled in FLUSH; a flush_done in the same cycle as the flush pulse returns to RUN on the next edge.
- retired_count updates on the edge following consume.

## Test plan
- Two valid ALU ops at the head (dest 3 = 0x11, dest 4 = 0x22) -> same cycle: consume=1, consume_count=1, rf_we={1,1}, rf_waddr={3,4}; retired_count goes 0 -> 2.
- Slot 0 writes $0, slot 1 is invalid -> consume=1, consume_count=0, rf_we[0]=0.
- Store at the head (addr 0x100, data 0xAB), st_ack held low 3 cycles -> st_req high from cycle 1 with stable addr/data; consume=0 until the ack cycle; then consume=1, consume_count=0, and st_req=0 one cycle later.
- ALU op in slot 0, store in slot 1 -> cycle 0 retires slot 0 only (consume_count=0). Next cycle the store reaches the head and st_req asserts.
- Faulting head, slot_pc[0]=0x400 -> flush=1 for one cycle with flush_pc=0x400; no consume or rf_we until flush_done; then RUN resumes.
- reset_n pulsed low during ST_WAIT -> st_req=0 immediately, state is RUN, retired_count=0.

Source files
------------

// File: rtl/rob_retire_ctl_if.sv
// Retirement-controller bus: ROB head slots in, consume/register-file/store/flush out.
// master = the retirement controller, slave = the ROB / register-file / memory side.
interface rob_retire_ctl_if #(
  parameter int EXT_COUNT = 2
);
  localparam int EXTCOUNTLOG2 = (EXT_COUNT > 1) ? $clog2(EXT_COUNT) : 1;

  logic [EXT_COUNT-1:0]         slot_valid;
  logic [EXT_COUNT-1:0][4:0]    slot_dest_reg;
  logic [EXT_COUNT-1:0]         slot_dest_valid;
  logic [EXT_COUNT-1:0][31:0]   slot_result;
  logic [EXT_COUNT-1:0]         slot_is_store;
  logic [EXT_COUNT-1:0][31:0]   slot_st_addr;
  logic [EXT_COUNT-1:0][31:0]   slot_st_data;
  logic [EXT_COUNT-1:0]         slot_exc;
  logic [EXT_COUNT-1:0][31:0]   slot_pc;
  logic                         empty;

  logic                         consume;
  logic [EXTCOUNTLOG2-1:0]      consume_count;
  logic [EXT_COUNT-1:0]         rf_we;
  logic [EXT_COUNT-1:0][4:0]    rf_waddr;
  logic [EXT_COUNT-1:0][31:0]   rf_wdata;

  logic                         st_req;
  logic [31:0]                  st_addr;
  logic [31:0]                  st_data;
  logic                         st_ack;

  logic                         flush;
  logic [31:0]                  flush_pc;
  logic                         flush_done;

  logic [31:0]                  retired_count;

  modport master (
    input  slot_valid, slot_dest_reg, slot_dest_valid, slot_result, slot_is_store,
           slot_st_addr, slot_st_data, slot_exc, slot_pc, empty, st_ack, flush_done,
    output consume, consume_count, rf_we, rf_waddr, rf_wdata,
           st_req, st_addr, st_data, flush, flush_pc, retired_count
  );

  modport slave (
    output slot_valid, slot_dest_reg, slot_dest_valid, slot_result, slot_is_store,
           slot_st_addr, slot_st_data, slot_exc, slot_pc, empty, st_ack, flush_done,
    input  consume, consume_count, rf_we, rf_waddr, rf_wdata,
           st_req, st_addr, st_data, flush, flush_pc, retired_count
  );
endinterface

// File: rtl/rob_retire_ctl.sv
// In-order ROB retirement: retires up to EXT_COUNT completed head entries per cycle,
// commits stores one at a time and raises a flush on a faulting head.
module rob_retire_lane (
  input  logic       prev_ok,
  input  logic       valid,
  input  logic       exc,
  input  logic       is_store,
  input  logic       dest_valid,
  input  logic [4:0] dest_reg,
  output logic       ok,
  output logic       we
);
  // A lane retires only if every older lane did and it is a plain completed op.
  assign ok = prev_ok & valid & ~exc & ~is_store;
  assign we = ok & dest_valid & (|dest_reg);
endmodule

module rob_retire_ctl #(
  parameter int EXT_COUNT = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  rob_retire_ctl_if.master  bus
);
  localparam int EXTCOUNTLOG2 = (EXT_COUNT > 1) ? $clog2(EXT_COUNT) : 1;

  typedef enum logic [1:0] {RUN, ST_WAIT, FLUSH} state_t;
  state_t state;

  logic [EXT_COUNT:0]   ok_chain;
  logic [EXT_COUNT-1:0] we_lane;

  assign ok_chain[0] = (state == RUN) & ~bus.empty;

  for (genvar i = 0; i < EXT_COUNT; i++) begin : g_lane
    rob_retire_lane u_lane (
      .prev_ok    (ok_chain[i]),
      .valid      (bus.slot_valid[i]),
      .exc        (bus.slot_exc[i]),
      .is_store   (bus.slot_is_store[i]),
      .dest_valid (bus.slot_dest_valid[i]),
      .dest_reg   (bus.slot_dest_reg[i]),
      .ok         (ok_chain[i+1]),
      .we         (we_lane[i])
    );
  end

  assign bus.rf_we    = we_lane;
  assign bus.rf_waddr = bus.slot_dest_reg;
  assign bus.rf_wdata = bus.slot_result;

  // The store retires on its ack cycle; the chain is idle outside RUN so count is 0 there.
  assign bus.consume       = (state == ST_WAIT) ? bus.st_ack : ok_chain[1];
  assign bus.consume_count = (EXT_COUNT > 1) ? EXTCOUNTLOG2'(ok_chain[EXT_COUNT]) : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= RUN;
      bus.st_req        <= 1'b0;
      bus.st_addr       <= '0;
      bus.st_data       <= '0;
      bus.flush         <= 1'b0;
      bus.flush_pc      <= '0;
      bus.retired_count <= '0;
    end else begin
      if (bus.consume)
        bus.retired_count <= bus.retired_count + 32'(bus.consume_count) + 32'd1;
      case (state)
        RUN: begin
          if (!bus.empty && bus.slot_valid[0]) begin
            if (bus.slot_exc[0]) begin
              bus.flush    <= 1'b1;
              bus.flush_pc <= bus.slot_pc[0];
              state        <= FLUSH;
            end else if (bus.slot_is_store[0]) begin
              bus.st_req  <= 1'b1;
              bus.st_addr <= bus.slot_st_addr[0];
              bus.st_data <= bus.slot_st_data[0];
              state       <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bus.st_ack) begin
            bus.st_req <= 1'b0;
            state      <= RUN;
          end
        end
        FLUSH: begin
          bus.flush <= 1'b0;
          if (bus.flush_done) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
